// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: 800x480 panel timing (hsync/vsync/de/x/y/frame_start), gated by a synchronised PLL lock.
// Define LCD_TIMING_TESTPAT_EN to build the 8-bar colour test pattern on rgb; otherwise rgb is tied to zero.
module lcd_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 210,
    parameter int H_SYNC   = 20,
    parameter int H_BP     = 26,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 22,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 13,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pll_locked,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start,
    output logic [23:0] rgb
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [0:0]  IDLE = 1'b0;
    localparam logic [0:0]  RUN  = 1'b1;

    logic        lock_q;
    logic        lock_s;
    logic [0:0]  state;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        run_ok;
    logic        de_c;
    logic        hs_c;
    logic        vs_c;

    // Outputs only decode while running and still locked, so a lost lock blanks on the same edge as the restart.
    assign run_ok = (state == RUN) && lock_s;
    assign de_c   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_c   = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_c   = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_q <= pll_locked;
            lock_s <= lock_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!run_ok) begin
            state <= lock_s ? RUN : IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 11'd1;
            if (h_cnt == H_LAST)
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de          <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            de          <= run_ok && de_c;
            hsync       <= (run_ok && hs_c) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (run_ok && vs_c) ? SYNC_POL : ~SYNC_POL;
            pix_x       <= run_ok ? h_cnt : '0;
            pix_y       <= run_ok ? v_cnt : '0;
            frame_start <= run_ok && (h_cnt == '0) && (v_cnt == '0);
        end
    end

`ifdef LCD_TIMING_TESTPAT_EN
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);
    logic [2:0] bar;

    always_comb begin
        bar = '0;
        for (int k = 1; k < 8; k++)
            if (h_cnt >= 11'(k) * BAR_W) bar = 3'(k);
    end

    // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to R=~bar[1], G=~bar[2], B=~bar[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb <= '0;
        else rgb <= (run_ok && de_c) ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : '0;
    end
`else
    assign rgb = '0;
`endif
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: directed checks of lcd_timing_gen; a full-size instance for line timing and a
// reduced-size instance (56 x 31 total) so frame timing and lock loss fit a short run.
module tb_lcd_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pll_locked = 1'b1;
    int checks = 0;
    int failures = 0;

    logic d_hs, d_vs, d_de, d_fs, s_hs, s_vs, s_de, s_fs;
    logic [10:0] d_x, s_x;
    logic [9:0] d_y, s_y;
    logic [23:0] d_rgb, s_rgb;

    always #5 clk = ~clk;

    lcd_timing_gen u_dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .hsync(d_hs), .vsync(d_vs),
        .de(d_de), .pix_x(d_x), .pix_y(d_y), .frame_start(d_fs), .rgb(d_rgb)
    );

    lcd_timing_gen #(
        .H_ACTIVE(40), .H_FP(8), .H_SYNC(4), .H_BP(4),
        .V_ACTIVE(24), .V_FP(3), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .hsync(s_hs), .vsync(s_vs),
        .de(s_de), .pix_x(s_x), .pix_y(s_y), .frame_start(s_fs), .rgb(s_rgb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_de"}, 32'(d_de), 0);
        check({tag, "_hs"}, 32'(d_hs), 1);
        check({tag, "_vs"}, 32'(d_vs), 1);
        check({tag, "_x"}, 32'(d_x), 0);
        check({tag, "_y"}, 32'(d_y), 0);
        check({tag, "_fs"}, 32'(d_fs), 0);
        check({tag, "_rgb"}, 32'(d_rgb), 0);
        check({tag, "_s_de"}, 32'(s_de), 0);
    endtask

    initial begin
        int de_hi, hs_lo, hs_first, de_fall, x_bad, fs_cnt, rgb_nz;
        int vs_lo, vs_first, fs2_idx, de_blank, de_tot, found;
        repeat (3) @(negedge clk);
        check_idle("rst_a");
        repeat (3) @(negedge clk);
        check_idle("rst_b");
        pll_locked = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_idle("unlocked");

        // lock rises before E1; outputs become live after E4
        pll_locked = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("start_e%0d_de", k), 32'(d_de), 0);
        end
        @(negedge clk);
        check("start_de", 32'(d_de), 1);
        check("start_x", 32'(d_x), 0);
        check("start_y", 32'(d_y), 0);
        check("start_fs", 32'(d_fs), 1);
        check("start_s_fs", 32'(s_fs), 1);

        de_hi = 0; hs_lo = 0; hs_first = -1; de_fall = -1; x_bad = 0; fs_cnt = 0; rgb_nz = 0;
        for (int i = 0; i < 1056; i++) begin
            if (d_de) de_hi++;
            if (!d_de && de_fall < 0) de_fall = i;
            if (!d_hs) begin
                hs_lo++;
                if (hs_first < 0) hs_first = i;
            end
            if (d_x != 11'(i) || d_y != 10'd0) x_bad++;
            if (d_fs) fs_cnt++;
            if (d_rgb != 24'h0) rgb_nz++;
`ifdef LCD_TIMING_TESTPAT_EN
            if (i == 0) check("rgb_x0", 32'(d_rgb), 32'hFFFFFF);
            if (i == 150) check("rgb_x150", 32'(d_rgb), 32'hFFFF00);
            if (i == 350) check("rgb_x350", 32'(d_rgb), 32'h00FF00);
            if (i == 799) check("rgb_x799", 32'(d_rgb), 32'h000000);
            if (i == 900) check("rgb_blank", 32'(d_rgb), 32'h000000);
`endif
            @(negedge clk);
        end
        check("line_de_hi", de_hi, 800);
        check("line_de_fall", de_fall, 800);
        check("line_hs_lo", hs_lo, 20);
        check("line_hs_first", hs_first, 1010);
        check("line_xy", x_bad, 0);
        check("line_fs_cnt", fs_cnt, 1);
        check("line_vs", 32'(d_vs), 1);
`ifndef LCD_TIMING_TESTPAT_EN
        check("rgb_off", rgb_nz, 0);
`endif
        check("line2_de", 32'(d_de), 1);
        check("line2_x", 32'(d_x), 0);
        check("line2_y", 32'(d_y), 1);

        // small instance frame: 56 clks/line, 31 lines, vsync on lines 27..28
        found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            if (s_fs) found = 1;
            else @(negedge clk);
        end
        check("fs_wait", found, 1);
        vs_lo = 0; vs_first = -1; fs2_idx = -1; de_blank = 0; de_tot = 0; fs_cnt = 0;
        for (int i = 0; i < 3472; i++) begin
            if (!s_vs) begin
                vs_lo++;
                if (vs_first < 0) vs_first = i;
            end
            if (s_fs) begin
                fs_cnt++;
                if (i > 0 && fs2_idx < 0) fs2_idx = i;
            end
            if (s_de) de_tot++;
            if (s_de && s_y >= 10'd24) de_blank++;
            @(negedge clk);
        end
        check("frame_fs_cnt", fs_cnt, 2);
        check("frame_period", fs2_idx, 1736);
        check("frame_vs_lo", vs_lo, 224);
        check("frame_vs_first", vs_first, 1512);
        check("frame_de_blank", de_blank, 0);
        check("frame_de_tot", de_tot, 1920);

        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (s_y == 10'd10) found = 1;
            else @(negedge clk);
        end
        check("y10_wait", found, 1);
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("loss");
        check("loss_s_x", 32'(s_x), 0);
        check("loss_s_y", 32'(s_y), 0);
        check("loss_h_cnt", 32'(u_small.h_cnt), 0);
        check("loss_v_cnt", 32'(u_small.v_cnt), 0);
        repeat (5) @(negedge clk);
        check_idle("hold");

        pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        check("relock_e3_de", 32'(s_de), 0);
        @(negedge clk);
        check("relock_fs", 32'(s_fs), 1);
        check("relock_de", 32'(s_de), 1);
        check("relock_x", 32'(s_x), 0);
        check("relock_y", 32'(s_y), 0);
        check("relock_d_fs", 32'(d_fs), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Video timing generator clocked by the 33 MHz pixel clock from the PLL. It also consumes that PLL's locked flag.
- Produces hsync, vsync, data-enable and pixel coordinates for an 800x480 panel at about 59.5 Hz (1056 x 525 total).
- Held idle until the PLL is locked. Restarts cleanly from the top-left pixel after any loss of lock.
- Downstream pixel sources use x/y/de to fetch pixel data.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 210, horizontal front porch (clocks)
- H_SYNC, 20, hsync width (clocks)
- H_BP, 26, horizontal back porch (clocks); H_TOTAL = sum of the four = 1056
- V_ACTIVE, 480, visible lines per frame
- V_FP, 22, vertical front porch (lines)
- V_SYNC, 10, vsync width (lines)
- V_BP, 13, vertical back porch (lines); V_TOTAL = sum of the four = 525
- SYNC_POL, 0, sync polarity during the pulse (0 = active-low, 1 = active-high)

Ports:
- clk  input  1  pixel clock (33 MHz PLL output)
- rst_n  input  1  asynchronous active-low reset
- pll_locked  input  1  PLL lock flag; asynchronous to clk, synchronised internally
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- de  output  1  data enable, high for active pixels
- pix_x  output  11  column of the current pixel (0..H_ACTIVE-1 when de=1)
- pix_y  output  10  row of the current pixel (0..V_ACTIVE-1 when de=1)
- frame_start  output  1  one-cycle pulse coincident with pixel (0,0)
- rgb  output  24  test pattern pixel {R,G,B}; see Optional Feature

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, both sync flops=0, h_cnt=0, v_cnt=0.
  - de=0, frame_start=0, pix_x=0, pix_y=0, rgb=0.
  - hsync=vsync=~SYNC_POL (inactive level).
- Lock synchroniser: 2-flop chain on pll_locked gives lock_s.
- FSM:
  - IDLE: counters held at 0, all outputs at their reset values. lock_s=1 -> RUN.
  - RUN: lock_s=0 -> IDLE on the next edge, with counters and outputs forced to reset values on that edge. Otherwise the counters advance.
- Counters (RUN only):
  - h_cnt counts 0..H_TOTAL-1, wraps to 0.
  - On each h wrap, v_cnt counts 0..V_TOTAL-1, wraps to 0.
  - Simultaneous wrap of both (h=H_TOTAL-1, v=V_TOTAL-1) -> (0,0).
- Line layout: active 0..H_ACTIVE-1, then front porch, then sync, then back porch. Same ordering for lines within a frame.
- Decode (combinational on counters, then registered; every output has exactly 1 clk latency from the counter value and all outputs stay mutually aligned):
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hsync active iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vsync active iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; changes on the same clk as hsync/de at the line boundary
  - pix_x = h_cnt, pix_y = v_cnt; undefined-but-stable content is not permitted, they always track the counters
  - frame_start = (h_cnt==0 && v_cnt==0) in RUN
- Start-up latency:
  - pll_locked rises before edge E1; lock_s=1 after E2; RUN with counters (0,0) after E3.
  - Outputs after E4 show de=1, pix_x=0, pix_y=0, frame_start=1.
- pll_locked glitch shorter than one clk may be missed; any glitch that is sampled causes a full restart.
- Counter widths: 11 bits for h, 10 bits for v. Parameter sets with H_TOTAL>2048 or V_TOTAL>1024 are unsupported.

Optional Feature:
- Macro: LCD_TIMING_TESTPAT_EN.
- Defined:
  - rgb is registered and aligned with de.
  - 8 vertical colour bars, each H_ACTIVE/8 pixels wide. Bar index = pix_x / (H_ACTIVE/8), values 0..7.
  - Colours in bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - rgb = 0 whenever de=0.
- Undefined: rgb tied to 24'h000000 and no pattern logic is built. All other behaviour is identical.

Test Plan:
- Reset values: rst_n=0 with pll_locked=1 -> de=0, hsync=vsync=1 (SYNC_POL=0), pix_x=pix_y=0, frame_start=0, held for the whole reset.
- Lock start-up: release reset, raise pll_locked -> first de=1 with pix_x=0, pix_y=0 and frame_start=1 exactly 4 edges after pll_locked is first sampled.
- Line timing: over one line -> de high for 800 clks, low for 256 clks; hsync low for exactly 20 clks starting 210 clks after de falls; period 1056 clks.
- Frame timing: over two frames -> frame_start period 554400 clks; vsync low for 10 lines (10560 clks) beginning at line 502; de never high on lines 480..524.
- Lock loss mid-frame: drop pll_locked at pix_y=100 -> within 3 edges de=0 and counters are 0; re-lock restarts with frame_start at (0,0).
- Test pattern (macro defined): pix_x=0 -> rgb=FFFFFF; pix_x=350 -> 00FF00; pix_x=799 -> 000000; rgb=0 in blanking. Macro undefined -> rgb always 0.
